lc_seq_ctrl: RTL and testbench
==============================

LC_SEQ_CTRL -- requirements
Module: lc_seq_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of job length and element counter.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 2, datapath latency from last operand pair to valid chain output.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, input-starvation limit used only under LC_SEQ_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  job request, sampled only in IDLE.
REQ-007 SHALL have port len  input  LEN_W  number of a/b pairs in job, latched with start.
REQ-008 SHALL have port busy  output  1  high in any state except IDLE.
REQ-009 SHALL have ports in_valid input 1, in_ready output 1, a_in input 32 signed, b_in input 32 signed: operand stream.
REQ-010 SHALL have ports dp_clr output 1, dp_a output 32, dp_b output 32: drive to MAC chain (dp_clr ORed into chain reset by integrator).
REQ-011 SHALL have port dp_out  input  32 signed  MAC chain result.
REQ-012 SHALL have ports res_valid output 1, res_ready input 1, res_data output 32 signed: result handshake.
REQ-013 SHALL have port err  output  1  job aborted flag, valid with res_valid.

Function
REQ-014 SHALL implement FSM states IDLE, CLR, LOAD, DRAIN, DONE.
REQ-015 IDLE: start=1 SHALL latch len and go to CLR; start in any other state SHALL be ignored.
REQ-016 CLR: SHALL assert dp_clr for exactly one cycle with dp_a=dp_b=0; next state LOAD, or DRAIN if latched len==0.
REQ-017 LOAD: in_ready SHALL be 1; in_ready SHALL be 0 in all other states.
REQ-018 On handshake (in_valid&in_ready), dp_a/dp_b SHALL register a_in/b_in; on every other cycle they SHALL register 0.
REQ-019 Element counter (LEN_W bits) SHALL increment per handshake; handshake with count==len-1 SHALL transition to DRAIN.
REQ-020 DRAIN: SHALL last exactly DRAIN_CYCLES+1 cycles with zero operands; final DRAIN edge SHALL capture dp_out into res_data and go to DONE.
REQ-021 DONE: res_valid=1, res_data and err held stable until res_ready=1; handshake SHALL return to IDLE.
REQ-022 start asserted in the DONE-accept cycle SHALL be ignored; a new job needs start while in IDLE.
REQ-023 res_data SHALL be dp_out unmodified (no saturation, no rescaling); len==0 job SHALL yield the cleared-chain value.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, counters 0, busy/in_ready/dp_clr/res_valid/err 0, dp_a/dp_b/res_data 0, regardless of state.
REQ-025 Reset mid-job SHALL discard the job; no res_valid SHALL follow until a new start.

Configuration
REQ-026 With LC_SEQ_TIMEOUT_EN defined: LOAD SHALL count consecutive non-handshake cycles (reset on each handshake); reaching TIMEOUT_CYCLES SHALL go to DONE with res_data=0, err=1.
REQ-027 Without LC_SEQ_TIMEOUT_EN: LOAD SHALL wait indefinitely, no timeout counter SHALL exist, err SHALL be tied 0.

Verification
REQ-028 len=3, pairs (1,4),(2,5),(3,6) back-to-back, res_ready=1 -> one dp_clr pulse, res_data=32, err=0, busy low after accept.
REQ-029 len=2 with in_valid gaps of 5 cycles between pairs (7,-3),(-2,10) -> res_data=-41; dp_a/dp_b=0 in gap cycles.
REQ-030 len=0, start -> CLR then DRAIN (DRAIN_CYCLES+1 cycles), res_valid with cleared-chain value, in_ready never 1.
REQ-031 res_ready held 0 for 10 cycles in DONE, start pulsed -> res_data stable, start ignored, IDLE one cycle after accept.
REQ-032 rst pulsed after 2 of 4 pairs -> all outputs 0 next cycle, no res_valid; new len=1 job (5,5) -> res_data=25.
REQ-033 LC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, len=4, only 1 pair sent -> 8 idle cycles later DONE with res_data=0, err=1.

Source files
------------

// File: rtl/lc_seq_ctrl.sv
// Sequencer for an external multiply-accumulate chain: clears the chain, streams operand pairs, drains, returns the result.
// Optional build macro LC_SEQ_TIMEOUT_EN aborts a job whose operand stream stalls for TIMEOUT_CYCLES cycles.
module lc_seq_ctrl #(
  parameter int LEN_W          = 16,
  parameter int DRAIN_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] a_in,
  input  logic signed [31:0] b_in,
  output logic               dp_clr,
  output logic [31:0]        dp_a,
  output logic [31:0]        dp_b,
  input  logic signed [31:0] dp_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [31:0] res_data,
  output logic               err,
  output logic [2:0]         dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int              DW         = $clog2(DRAIN_CYCLES + 2);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYCLES);

  logic [2:0]         state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [31:0]        dp_a_q, dp_a_d;
  logic [31:0]        dp_b_q, dp_b_d;
  logic signed [31:0] res_q, res_d;
  logic               hs;

  // Both streams use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the producer holds data while valid && !ready.
  assign hs = in_valid & in_ready;

`ifdef LC_SEQ_TIMEOUT_EN
  localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    res_d   = res_q;
    dp_a_d  = hs ? a_in : 32'd0;
    dp_b_d  = hs ? b_in : 32'd0;
`ifdef LC_SEQ_TIMEOUT_EN
    to_d    = to_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          state_d = S_CLR;
`ifdef LC_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_CLR: begin
        drain_d = '0;
        state_d = (len_q == '0) ? S_DRAIN : S_LOAD;
`ifdef LC_SEQ_TIMEOUT_EN
        to_d    = '0;
`endif
      end
      S_LOAD: begin
        if (hs) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
`ifdef LC_SEQ_TIMEOUT_EN
          to_d = '0;
        end else if (to_q == TO_LAST) begin
          // Stalled stream: abandon the partial sum and flag the job.
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_d = to_q + TO_W'(1);
`endif
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          res_d   = dp_out;
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      dp_a_q  <= '0;
      dp_b_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      dp_a_q  <= dp_a_d;
      dp_b_q  <= dp_b_d;
      res_q   <= res_d;
    end
  end

`ifdef LC_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_LOAD);
  assign dp_clr    = (state_q == S_CLR);
  assign res_valid = (state_q == S_DONE);
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign res_data  = res_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lc_seq_ctrl.sv
// Bench for lc_seq_ctrl: directed and random jobs against a sum-of-products scoreboard,
// with a simple accumulator standing in for the external MAC chain.
module tb_lc_seq_ctrl;
  localparam int LEN_W          = 16;
  localparam int DRAIN_CYCLES   = 2;
  localparam int TIMEOUT_CYCLES = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [LEN_W-1:0]   len;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] a_in;
  logic signed [31:0] b_in;
  logic               dp_clr;
  logic [31:0]        dp_a;
  logic [31:0]        dp_b;
  logic signed [31:0] dp_out;
  logic               res_valid;
  logic               res_ready;
  logic signed [31:0] res_data;
  logic               err;
  logic [2:0]         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int clr_cnt  = 0;
  int rdy_cnt  = 0;

  logic [32:0]        exp_q[$];
  logic signed [31:0] pa[$];
  logic signed [31:0] pb[$];
  int                 pg[$];

  lc_seq_ctrl #(
    .LEN_W(LEN_W), .DRAIN_CYCLES(DRAIN_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .dp_clr(dp_clr), .dp_a(dp_a), .dp_b(dp_b), .dp_out(dp_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // MAC chain stand-in: accumulator followed by DRAIN_CYCLES-1 delay stages
  logic signed [31:0] chain [DRAIN_CYCLES];
  always @(posedge clk or posedge rst) begin
    if (rst || dp_clr) begin
      for (int i = 0; i < DRAIN_CYCLES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= chain[0] + $signed(dp_a) * $signed(dp_b);
      for (int i = 1; i < DRAIN_CYCLES; i++) chain[i] <= chain[i-1];
    end
  end
  assign dp_out = chain[DRAIN_CYCLES-1];

  always @(posedge clk) begin
    if (dp_clr)   clr_cnt <= clr_cnt + 1;
    if (in_ready) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic start_job(input int n);
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(n);
    clr_cnt = 0;
    rdy_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    check_eq("clr_pulse", {busy, dp_clr, in_ready}, 3'b110);
    check_eq("clr_dp_zero", {dp_a, dp_b}, 64'd0);
  endtask

  task automatic send_pair(input logic signed [31:0] a, input logic signed [31:0] b, input int gap);
    int t = 0;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("gap_dp_zero", {dp_a, dp_b}, 64'd0);
    end
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("ready_timeout", (t < 50), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("dp_pair", {dp_a, dp_b}, {a, b});
  endtask

  task automatic wait_result(input int exp_cycles);
    int n = 0;
    while (!res_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_eq("result_latency", n, exp_cycles);
  endtask

  task automatic accept(input int hold, input bit poke);
    logic [32:0] held;
    logic [32:0] exp;
    held = {err, res_data};
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      start = poke && (i == hold / 2);
      @(negedge clk);
      check_eq("res_hold", {res_valid, err, res_data}, {1'b1, held});
    end
    start = poke;
    res_ready = 1'b1;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 33'bx;
    check_eq("scoreboard", {err, res_data}, exp);
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    check_eq("idle_after_accept", {busy, res_valid}, 2'b00);
    check_eq("clr_count", clr_cnt, 1);
    @(negedge clk);
    check_eq("still_idle", busy, 0);
  endtask

  task automatic run_job(input int hold, input bit poke);
    int n;
    logic signed [31:0] sum;
    n = pa.size();
    sum = 0;
    for (int i = 0; i < n; i++) sum += pa[i] * pb[i];
    exp_q.push_back({1'b0, sum});
    start_job(n);
    if (n == 0) @(negedge clk);
    for (int i = 0; i < n; i++) send_pair(pa[i], pb[i], pg[i]);
    wait_result(DRAIN_CYCLES + 1);
    if (n == 0) check_eq("len0_no_ready", rdy_cnt, 0);
    accept(hold, poke);
  endtask

  task automatic set_pairs(input int n);
    pa.delete(); pb.delete(); pg.delete();
    for (int i = 0; i < n; i++) begin
      pa.push_back($signed($urandom));
      pb.push_back($signed($urandom));
      pg.push_back($urandom_range(0, 3));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv_seen;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    a_in = '0; b_in = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_ctrl", {busy, in_ready, dp_clr, res_valid, err, dbg_state}, 8'd0);
    check_eq("reset_data", {dp_a | dp_b, res_data}, 64'd0);
    rst = 1'b0;

    // three back-to-back pairs
    pa = '{32'sd1, 32'sd2, 32'sd3}; pb = '{32'sd4, 32'sd5, 32'sd6}; pg = '{0, 0, 0};
    run_job(0, 0);

    // gapped stream with signed operands
    pa = '{32'sd7, -32'sd2}; pb = '{-32'sd3, 32'sd10}; pg = '{0, 5};
    run_job(0, 0);

    // empty job
    pa.delete(); pb.delete(); pg.delete();
    run_job(0, 0);

    // back-pressure on the result with start poked while waiting
    pa = '{32'sd9}; pb = '{-32'sd9}; pg = '{2};
    run_job(10, 1);

    // reset mid-job
    start_job(4);
    send_pair(32'sd1, 32'sd1, 0);
    send_pair(32'sd2, 32'sd2, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midjob_rst_ctrl", {busy, in_ready, dp_clr, res_valid, err}, 5'd0);
    check_eq("midjob_rst_data", {dp_a | dp_b, res_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid || busy) rv_seen++;
    end
    check_eq("no_result_after_rst", rv_seen, 0);
    pa = '{32'sd5}; pb = '{32'sd5}; pg = '{0};
    run_job(0, 0);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      set_pairs($urandom_range(0, 6));
      run_job($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

`ifdef LC_SEQ_TIMEOUT_EN
    // stalled stream aborts with err set and zero result
    exp_q.push_back({1'b1, 32'd0});
    start_job(4);
    send_pair(32'sd3, 32'sd3, 0);
    wait_result(TIMEOUT_CYCLES);
    accept(0, 0);
`endif

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
